// File: rtl/pkt_hdr_pkg.sv
// Shared constants and FSM state type for the Ethernet/IPv4 header parser.
package pkt_hdr_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [15:0] ETH_TYPE_VLAN  = 16'h8100;
  localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
  localparam logic [15:0] VLAN_TAG_LEN   = 16'd4;
  localparam logic [15:0] IPV4_PROTO_OFS = 16'd9;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  localparam logic [3:0]  IPV4_MIN_IHL   = 4'd5;

  typedef enum logic [2:0] {
    ST_SOP  = 3'd0,
    ST_ETH  = 3'd1,
    ST_VLAN = 3'd2,
    ST_IP   = 3'd3,
    ST_SKIP = 3'd4
  } pkt_state_e;

endpackage

// File: rtl/pkt_pipe_reg.sv
// Single-entry registered pass-through stage between the MAC byte stream and the packet FIFO.
// Handshake: a byte moves on a rising edge when valid && ready; valid never waits on ready.
module pkt_pipe_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       last_q;

  // The stage can take a new byte whenever its current one leaves or it is empty.
  assign in_ready = out_ready || !valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'd0;
      last_q  <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
        last_q <= in_last;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/pkt_hdr_parser.sv
// Ethernet (optional single 802.1Q tag) / IPv4 header parser sitting beside a one-stage
// pass-through register; reports header offsets and classification once per packet.
module pkt_hdr_parser
  import pkt_hdr_pkg::*;
#(
  parameter bit VLAN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        pkt_sop,
  output logic [15:0] l2_offset,
  output logic [15:0] l3_offset,
  output logic [15:0] l4_offset,
  output logic [7:0]  ip_proto,
  output logic        is_ipv4,
  output logic        has_vlan,
  output logic        hdr_valid,
  output logic        parse_err,
  output pkt_state_e  dbg_state
);

  pkt_state_e  state_q, state_d;
  logic [15:0] byte_idx_q, byte_idx_d;
  logic [7:0]  etype_hi_q, etype_hi_d;
  logic [15:0] l3_q, l3_d, l4_q, l4_d;
  logic [7:0]  proto_q, proto_d;
  logic        ipv4_q, ipv4_d, vlan_q, vlan_d, err_q, err_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        accept, etype_end, hdr_done;
  logic [15:0] etype, ihl_bytes;

  pkt_pipe_reg u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  assign accept    = in_valid && in_ready;
  assign etype     = {etype_hi_q, in_data};
  assign ihl_bytes = {10'd0, in_data[3:0], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_SOP;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx_q  <= 16'd0;
      etype_hi_q  <= 8'd0;
      l3_q        <= 16'd0;
      l4_q        <= 16'd0;
      proto_q     <= 8'd0;
      ipv4_q      <= 1'b0;
      vlan_q      <= 1'b0;
      err_q       <= 1'b0;
      hdr_valid_q <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      etype_hi_q  <= etype_hi_d;
      l3_q        <= l3_d;
      l4_q        <= l4_d;
      proto_q     <= proto_d;
      ipv4_q      <= ipv4_d;
      vlan_q      <= vlan_d;
      err_q       <= err_d;
      hdr_valid_q <= hdr_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    etype_hi_d  = etype_hi_q;
    l3_d        = l3_q;
    l4_d        = l4_q;
    proto_d     = proto_q;
    ipv4_d      = ipv4_q;
    vlan_d      = vlan_q;
    err_d       = err_q;
    hdr_valid_d = 1'b0;
    etype_end   = 1'b0;
    hdr_done    = 1'b0;
    if (accept) begin
      if (in_last)                      byte_idx_d = 16'd0;
      else if (byte_idx_q != 16'hFFFF)  byte_idx_d = byte_idx_q + 16'd1;
      case (state_q)
        ST_SOP: begin
          l3_d    = 16'd0;
          l4_d    = 16'd0;
          proto_d = 8'd0;
          ipv4_d  = 1'b0;
          vlan_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_ETH;
        end
        ST_ETH: begin
          if (byte_idx_q == ETH_HDR_LEN - 16'd2) etype_hi_d = in_data;
          if (byte_idx_q == ETH_HDR_LEN - 16'd1) begin
            if (VLAN_EN && etype == ETH_TYPE_VLAN) begin
              vlan_d  = 1'b1;
              l3_d    = ETH_HDR_LEN + VLAN_TAG_LEN;
              state_d = ST_VLAN;
            end else begin
              l3_d      = ETH_HDR_LEN;
              etype_end = 1'b1;
            end
          end
        end
        ST_VLAN: begin
          // The inner EtherType is the last two bytes before the L3 header.
          if (byte_idx_q == l3_q - 16'd2) etype_hi_d = in_data;
          if (byte_idx_q == l3_q - 16'd1) etype_end = 1'b1;
        end
        ST_IP: begin
          if (byte_idx_q == l3_q) begin
            l4_d = l3_q + ihl_bytes;
            if (in_data[7:4] != IPV4_VERSION || in_data[3:0] < IPV4_MIN_IHL) err_d = 1'b1;
          end
          if (byte_idx_q == l3_q + IPV4_PROTO_OFS) begin
            proto_d  = in_data;
            hdr_done = 1'b1;
            state_d  = ST_SKIP;
          end
        end
        default: ;
      endcase
      if (etype_end) begin
        if (etype == ETH_TYPE_IPV4) begin
          ipv4_d  = 1'b1;
          state_d = ST_IP;
        end else begin
          l4_d     = l3_d;
          hdr_done = 1'b1;
          state_d  = ST_SKIP;
        end
      end
      if (hdr_done) hdr_valid_d = 1'b1;
      // A packet ending before its header completed still reports once, flagged as an error.
      if (in_last) begin
        state_d = ST_SOP;
        if (state_q != ST_SKIP && !hdr_done) begin
          err_d       = 1'b1;
          hdr_valid_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pkt_sop   = rst_n && accept && (state_q == ST_SOP);
    dbg_state = state_q;
  end

  assign l2_offset = 16'd0;
  assign l3_offset = l3_q;
  assign l4_offset = l4_q;
  assign ip_proto  = proto_q;
  assign is_ipv4   = ipv4_q;
  assign has_vlan  = vlan_q;
  assign hdr_valid = hdr_valid_q;
  assign parse_err = err_q;

endmodule

// File: doc/pkt_hdr_parser.md
PKT_HDR_PARSER -- requirements
Module: pkt_hdr_parser

Interface
REQ-001 Parameter VLAN_EN, default 1, meaning: 1 enables parsing of a single 802.1Q tag (EtherType 0x8100).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid / in_data / in_last  input  1/8/1  receive byte stream from MAC; in_last marks final byte.
REQ-005 in_ready  output  1  accept; byte transfers when in_valid && in_ready.
REQ-006 out_valid / out_data / out_last  output  1/8/1  registered pass-through to packet FIFO.
REQ-007 out_ready  input  1  downstream accept.
REQ-008 pkt_sop  output  1  one-cycle pulse on input acceptance of a packet's first byte.
REQ-009 l2_offset / l3_offset / l4_offset  output  16 each  header byte offsets of current packet.
REQ-010 ip_proto  output  8  IPv4 protocol field; 0 if not IPv4.
REQ-011 is_ipv4 / has_vlan  output  1 each  packet classification flags.
REQ-012 hdr_valid  output  1  one-cycle pulse: offsets/flags final for current packet.
REQ-013 parse_err  output  1  qualified by hdr_valid: malformed or truncated header.

Function
REQ-014 Pass-through: single register stage, data/last unmodified, latency 1 cycle; in_ready = out_ready || !out_valid; no byte dropped, duplicated or reordered.
REQ-015 byte_index: 16-bit count of accepted bytes within packet, 0 for first byte, saturates at 0xFFFF; returns to 0 after accepted in_last.
REQ-016 FSM states: SOP (expect first byte), ETH (bytes 0-13), VLAN (tag bytes), IP (IPv4 header bytes), SKIP (payload until in_last); state advances only on accepted bytes.
REQ-017 SOP -> ETH on accepted byte; pkt_sop pulses that cycle; all result outputs cleared to 0 same cycle.
REQ-018 l2_offset is always 0.
REQ-019 EtherType = bytes 12,13 (big-endian); if 0x8100 and VLAN_EN=1: has_vlan=1, -> VLAN, EtherType taken from bytes 16,17, l3_offset=18; else l3_offset=14.
REQ-020 EtherType 0x0800 -> IP, is_ipv4=1; otherwise -> SKIP, l4_offset=l3_offset, hdr_valid pulses cycle after EtherType low byte accepted.
REQ-021 Byte l3_offset: upper nibble must equal 4 and IHL (lower nibble) must be >=5, else parse_err=1; l4_offset = l3_offset + IHL*4 (16-bit).
REQ-022 Byte l3_offset+9 -> ip_proto; hdr_valid pulses cycle after its acceptance; -> SKIP.
REQ-023 Accepted in_last before header complete: hdr_valid pulses next cycle with parse_err=1, partial offsets as captured; -> SOP.
REQ-024 Accepted in_last in SKIP -> SOP; hdr_valid pulses exactly once per packet.
REQ-025 Result outputs hold from hdr_valid until next pkt_sop.
REQ-026 Back-to-back packets: next first byte accepted the cycle after in_last with no bubble; pkt_sop may coincide with previous packet's hdr_valid.
REQ-027 in_valid low or in_ready low: no state, counter or result change.

Reset
REQ-028 rst_n low: out_valid, out_last, pkt_sop, hdr_valid, parse_err, is_ipv4, has_vlan = 0; out_data, offsets, ip_proto = 0; byte_index = 0; FSM = SOP.
REQ-029 Reset mid-packet: next accepted byte is treated as a new packet's first byte.

Structure
REQ-030 Shared package pkt_hdr_pkg holds ETH_TYPE_IPV4 (0x0800), ETH_TYPE_VLAN (0x8100), ETH_HDR_LEN (14), VLAN_TAG_LEN (4), IPV4_PROTO_OFS (9), FSM state type.
REQ-031 One sub-module pkt_pipe_reg implements the REQ-014 register stage; the parser FSM sits in pkt_hdr_parser top.

Verification
REQ-032 Untagged IPv4 TCP, IHL=5, 60 bytes -> hdr_valid once, l3=14, l4=34, ip_proto=0x06, is_ipv4=1, has_vlan=0, parse_err=0; output stream identical to input.
REQ-033 VLAN-tagged IPv4 UDP, IHL=6 -> has_vlan=1, l3=18, l4=42, ip_proto=0x11; with VLAN_EN=0 -> l3=14, is_ipv4=0, l4=14.
REQ-034 ARP frame (EtherType 0x0806) -> hdr_valid after byte 13, is_ipv4=0, l4=14, parse_err=0.
REQ-035 IPv4 frame ending at byte 20 (in_last) -> hdr_valid with parse_err=1; following packet parses correctly; version 6 nibble -> parse_err=1.
REQ-036 Random out_ready stalls (50%) plus back-to-back packets -> no data loss, one pkt_sop and one hdr_valid per packet, offsets match reference model.
REQ-037 rst_n asserted at byte 8 of a packet -> outputs per REQ-028; following complete packet parses correctly.
